// File: rtl/simd_mult_accumulator_9bits.sv
// Frame accumulator behind the 9x9 SIMD multiplier: full 9x9 or dual 4x4 lanes, 2-cycle latency.
// Define PIRDSP_ACC_SAT_EN for sticky saturating accumulation; the default build wraps modulo width.
//
// state | meaning
// IDLE  | no frame open; the next legal sample opens one (and may close it at once)
// ACCUM | frame open; matching samples counted down against the latched length
module simd_mult_accumulator_9bits #(
  parameter int ACC_W = 48,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [17:0]      C,
  input  logic             A_sign,
  input  logic             B_sign,
  input  logic             HALF_0,
  input  logic             HALF_1,
  input  logic             in_valid,
  input  logic [LEN_W-1:0] acc_len,
  input  logic             flush,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             err
);

  localparam int H  = ACC_W / 2;
  localparam int FX = ACC_W - 18;
  localparam int LX = H - 8;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state, state_nx;
  logic             mode_q, mode_nx;
  logic [LEN_W-1:0] remain_q, remain_nx;
  logic [LEN_W-1:0] len_eff;

  logic             prod_signed, legal, smp_dual;
  logic             take, token, first, last, drop;
  logic [ACC_W-1:0] ext_full, ext_prod;
  logic [H-1:0]     ext_l0, ext_l1;

  logic             s1_valid, s1_first, s1_last, s1_dual;
  logic [ACC_W-1:0] s1_prod;
  logic [ACC_W-1:0] acc_q, base, acc_nx;

  assign prod_signed = A_sign | B_sign;
  assign legal       = HALF_0 ^ HALF_1;
  assign smp_dual    = HALF_1;
  assign len_eff     = (acc_len == '0) ? LEN_W'(1) : acc_len;

  assign ext_full = prod_signed ? {{FX{C[17]}}, C} : {{FX{1'b0}}, C};
  assign ext_l0   = prod_signed ? {{LX{C[17]}}, C[17:10]} : {{LX{1'b0}}, C[17:10]};
  assign ext_l1   = prod_signed ? {{LX{C[7]}}, C[7:0]} : {{LX{1'b0}}, C[7:0]};
  assign ext_prod = smp_dual ? {ext_l0, ext_l1} : ext_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      remain_q <= '0;
    end else begin
      state    <= state_nx;
      mode_q   <= mode_nx;
      remain_q <= remain_nx;
    end
  end

  // remain_q counts the samples still owed after the current one; 1 means the next match closes.
  always_comb begin
    state_nx  = state;
    mode_nx   = mode_q;
    remain_nx = remain_q;
    take      = 1'b0;
    token     = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (legal) begin
            take    = 1'b1;
            first   = 1'b1;
            mode_nx = smp_dual;
            if (len_eff == LEN_W'(1) || flush) begin
              last = 1'b1;
            end else begin
              remain_nx = len_eff - LEN_W'(1);
              state_nx  = ACCUM;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (in_valid && legal && (smp_dual == mode_q)) begin
          take = 1'b1;
          if (remain_q == LEN_W'(1) || flush) begin
            last     = 1'b1;
            state_nx = IDLE;
          end else begin
            remain_nx = remain_q - LEN_W'(1);
          end
        end else begin
          drop = in_valid;
          // A flush with nothing to add still has to push a close marker down the pipe.
          if (flush) begin
            token    = 1'b1;
            last     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

`ifdef PIRDSP_ACC_SAT_EN
  logic s1_signed;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_dual  <= 1'b0;
      s1_prod  <= '0;
      err      <= 1'b0;
`ifdef PIRDSP_ACC_SAT_EN
      s1_signed <= 1'b0;
`endif
    end else begin
      s1_valid <= take | token;
      s1_first <= first;
      s1_last  <= last;
      s1_dual  <= take ? smp_dual : mode_q;
      s1_prod  <= take ? ext_prod : '0;
      err      <= drop;
`ifdef PIRDSP_ACC_SAT_EN
      s1_signed <= prod_signed;
`endif
    end
  end

  assign base = s1_first ? '0 : acc_q;

`ifdef PIRDSP_ACC_SAT_EN
  logic         sat_hi_q, sat_lo_q, sat_hi_nx, sat_lo_nx;
  logic [ACC_W:0] r_full;
  logic [H:0]   r_hi, r_lo;

  // Returns {clamped, value}.
  function automatic logic [ACC_W:0] sat_add_full(input logic [ACC_W-1:0] a,
                                                   input logic [ACC_W-1:0] b,
                                                   input logic sgn);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add_full = {1'b0, s[ACC_W-1:0]};
    if (sgn && (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]))
      sat_add_full = {1'b1, b[ACC_W-1], {(ACC_W-1){~b[ACC_W-1]}}};
    else if (!sgn && s[ACC_W])
      sat_add_full = {1'b1, {ACC_W{1'b1}}};
  endfunction

  function automatic logic [H:0] sat_add_lane(input logic [H-1:0] a,
                                              input logic [H-1:0] b,
                                              input logic sgn);
    logic [H:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add_lane = {1'b0, s[H-1:0]};
    if (sgn && (a[H-1] == b[H-1]) && (s[H-1] != a[H-1]))
      sat_add_lane = {1'b1, b[H-1], {(H-1){~b[H-1]}}};
    else if (!sgn && s[H])
      sat_add_lane = {1'b1, {H{1'b1}}};
  endfunction

  assign r_full = sat_add_full(base, s1_prod, s1_signed);
  assign r_hi   = sat_add_lane(base[ACC_W-1:H], s1_prod[ACC_W-1:H], s1_signed);
  assign r_lo   = sat_add_lane(base[H-1:0], s1_prod[H-1:0], s1_signed);

  // Once a lane has clamped it keeps its clamped value until the next frame's first sample.
  always_comb begin
    sat_hi_nx = sat_hi_q & ~s1_first;
    sat_lo_nx = sat_lo_q & ~s1_first;
    acc_nx    = base;
    if (s1_dual) begin
      if (!sat_hi_nx) {sat_hi_nx, acc_nx[ACC_W-1:H]} = r_hi;
      if (!sat_lo_nx) {sat_lo_nx, acc_nx[H-1:0]} = r_lo;
    end else begin
      if (!sat_hi_nx) {sat_hi_nx, acc_nx} = r_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else if (s1_valid) begin
      sat_hi_q <= sat_hi_nx;
      sat_lo_q <= sat_lo_nx;
    end
  end
`else
  logic [H-1:0] sum_hi, sum_lo;

  assign sum_hi = base[ACC_W-1:H] + s1_prod[ACC_W-1:H];
  assign sum_lo = base[H-1:0] + s1_prod[H-1:0];
  assign acc_nx = s1_dual ? {sum_hi, sum_lo} : (base + s1_prod);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc_q <= acc_nx;
        if (s1_last) acc_out <= acc_nx;
      end
    end
  end

endmodule

// File: tb/tb_simd_mult_accumulator_9bits.sv
// Bench for simd_mult_accumulator_9bits: directed vector table, saturation sequence on a 20-bit
// instance, then random traffic against a frame-level reference model.
module tb_simd_mult_accumulator_9bits;

  logic        clk = 1'b0;
  logic        reset, A_sign, B_sign, HALF_0, HALF_1, in_valid, flush;
  logic [17:0] C;
  logic [7:0]  acc_len;
  logic [47:0] acc_out;
  logic        out_valid, err;
  logic [19:0] acc_out20;
  logic        out_valid20, err20;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  simd_mult_accumulator_9bits dut (
    .clk(clk), .reset(reset), .C(C), .A_sign(A_sign), .B_sign(B_sign),
    .HALF_0(HALF_0), .HALF_1(HALF_1), .in_valid(in_valid), .acc_len(acc_len),
    .flush(flush), .acc_out(acc_out), .out_valid(out_valid), .err(err)
  );

  simd_mult_accumulator_9bits #(.ACC_W(20), .LEN_W(8)) dut20 (
    .clk(clk), .reset(reset), .C(C), .A_sign(A_sign), .B_sign(B_sign),
    .HALF_0(HALF_0), .HALF_1(HALF_1), .in_valid(in_valid), .acc_len(acc_len),
    .flush(flush), .acc_out(acc_out20), .out_valid(out_valid20), .err(err20)
  );

  typedef struct {
    logic        rst, vld, h0, h1, a_s, b_s;
    logic [17:0] c;
    logic [7:0]  len;
    logic        fl;
    logic        eov;
    logic [47:0] eacc;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(logic rst, logic vld, logic h0, logic h1, logic a_s, logic b_s,
                              logic [17:0] c, logic [7:0] len, logic fl,
                              logic eov, logic [47:0] eacc, logic eerr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.h0 = h0; v.h1 = h1; v.a_s = a_s; v.b_s = b_s;
    v.c = c; v.len = len; v.fl = fl; v.eov = eov; v.eacc = eacc; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; in_valid = v.vld; HALF_0 = v.h0; HALF_1 = v.h1;
    A_sign = v.a_s; B_sign = v.b_s; C = v.c; acc_len = v.len; flush = v.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: frame bookkeeping with plain integer sums.
  bit     m_open, m_dual;
  int     m_len, m_cnt;
  longint m_full, m_l0, m_l1;

  task automatic model_edge(output bit cl, output logic [47:0] v, output bit e);
    bit     sg, lg, dl;
    longint p_full, p0, p1;
    logic [7:0] b0, b1;
    sg = A_sign | B_sign;
    lg = (HALF_0 != HALF_1);
    dl = HALF_1;
    b0 = C[17:10];
    b1 = C[7:0];
    p_full = sg ? longint'($signed(C)) : longint'(C);
    p0 = sg ? longint'($signed(b0)) : longint'(b0);
    p1 = sg ? longint'($signed(b1)) : longint'(b1);
    cl = 1'b0;
    e  = 1'b0;
    v  = '0;
    if (reset) begin
      m_open = 1'b0;
      return;
    end
    if (!m_open) begin
      if (in_valid) begin
        if (!lg) e = 1'b1;
        else begin
          m_dual = dl;
          m_len  = (acc_len == 0) ? 1 : int'(acc_len);
          m_cnt  = 1;
          m_full = p_full; m_l0 = p0; m_l1 = p1;
          if (m_cnt == m_len || flush) cl = 1'b1;
          else m_open = 1'b1;
        end
      end
    end else begin
      if (in_valid && lg && dl == m_dual) begin
        m_cnt++;
        m_full += p_full; m_l0 += p0; m_l1 += p1;
        if (m_cnt == m_len || flush) begin cl = 1'b1; m_open = 1'b0; end
      end else begin
        if (in_valid) e = 1'b1;
        if (flush) begin cl = 1'b1; m_open = 1'b0; end
      end
    end
    if (cl) v = m_dual ? {m_l0[23:0], m_l1[23:0]} : m_full[47:0];
  endtask

  initial begin
    vec_t vecs[$];
    logic [47:0] last_exp, val_d1, v;
    logic [19:0] sat_exp;
    bit ov_d1, cl, e, exp_ov;

    // rst vld h0 h1 a_s b_s c len fl | eov eacc eerr
    vecs.push_back(mk(1,0,0,0,0,0, 18'h0, 8'd0, 0, 0, 48'h0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,1,0,0,0, 18'h3FC01, 8'd4, 0, 0, 48'h0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'h0, 8'd0, 0, 1, 48'hFF004, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,1,0,1,0, 18'h30100, 8'd3, 0, 0, 48'hFF004, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'h0, 8'd0, 0, 1, 48'hFFFF_FFFD_0300, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0,1,0,1,1,1, 18'h100C8, 8'd2, 0, 0, 48'hFFFF_FFFD_0300, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'h0, 8'd0, 0, 1, 48'h000080_FFFF90, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,1,0,0,0, 18'd100, 8'd10, 0, 0, 48'h000080_FFFF90, 0));
    vecs.push_back(mk(0,1,0,1,0,0, 18'd100, 8'd10, 0, 0, 48'h000080_FFFF90, 1));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd10, 1, 0, 48'h000080_FFFF90, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd10, 0, 1, 48'd300, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0,1,1,0,0,0, 18'd7, 8'd2, 0, 0, 48'd300, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd2, 0, 1, 48'd14, 0));
    vecs.push_back(mk(0,1,1,0,0,0, 18'd3, 8'd10, 0, 0, 48'd14, 0));
    vecs.push_back(mk(0,1,1,0,0,0, 18'd4, 8'd10, 1, 0, 48'd14, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd10, 0, 1, 48'd7, 0));
    vecs.push_back(mk(0,1,1,0,0,0, 18'd9, 8'd10, 1, 0, 48'd7, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd10, 0, 1, 48'd9, 0));
    vecs.push_back(mk(0,1,1,0,0,0, 18'd11, 8'd0, 0, 0, 48'd9, 0));
    vecs.push_back(mk(0,1,1,0,0,0, 18'd12, 8'd0, 0, 1, 48'd11, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd0, 0, 1, 48'd12, 0));
    vecs.push_back(mk(0,1,1,1,0,0, 18'd55, 8'd4, 0, 0, 48'd12, 1));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd4, 0, 0, 48'd12, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0,1,1,0,0,0, 18'd5, 8'd4, 0, 0, 48'd12, 0));
    vecs.push_back(mk(1,0,0,0,0,0, 18'd0, 8'd4, 0, 0, 48'd0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,1,0,0,0, 18'd5, 8'd4, 0, 0, 48'd0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd4, 0, 1, 48'd20, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 18'd0, 8'd4, 0, 0, 48'd20, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].eov));
      chk($sformatf("vec%0d acc_out", i), 64'(acc_out), 64'(vecs[i].eacc));
      chk($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].eerr));
    end

    // Dual unsigned 15*15 per lane, five samples, on the 20-bit instance.
`ifdef PIRDSP_ACC_SAT_EN
    sat_exp = {10'd1023, 10'd1023};
`else
    sat_exp = {10'd101, 10'd101};
`endif
    drive(mk(1,0,0,0,0,0, 18'h0, 8'd5, 0, 0, 48'h0, 0));
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(mk(0,1,0,1,0,0, 18'h384E1, 8'd5, 0, 0, 48'h0, 0));
      tick();
      chk($sformatf("sat early out_valid%0d", i), 64'(out_valid20), 64'(0));
      chk($sformatf("sat err%0d", i), 64'(err20), 64'(0));
    end
    drive(mk(0,0,0,0,0,0, 18'h0, 8'd5, 0, 0, 48'h0, 0));
    tick();
    chk("sat out_valid", 64'(out_valid20), 64'(1));
    chk("sat acc_out20", 64'(acc_out20), 64'(sat_exp));
    chk("sat wide acc_out", 64'(acc_out), 64'({24'd1125, 24'd1125}));
    tick();
    chk("sat pulse width", 64'(out_valid20), 64'(0));

    // Random traffic against the model; the first cycle is a reset to align state.
    ov_d1 = 1'b0;
    val_d1 = '0;
    last_exp = '0;
    for (int i = 0; i < 800; i++) begin
      int md;
      reset    = (i == 0) || ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      md       = $urandom_range(0, 19);
      HALF_0   = (md < 9) || (md == 19);
      HALF_1   = ((md >= 9) && (md < 18)) || (md == 19);
      A_sign   = $urandom_range(0, 1) == 1;
      B_sign   = $urandom_range(0, 3) == 0;
      C        = 18'($urandom);
      acc_len  = 8'($urandom_range(0, 4));
      flush    = ($urandom_range(0, 9) == 0);
      model_edge(cl, v, e);
      exp_ov = reset ? 1'b0 : ov_d1;
      if (exp_ov) last_exp = val_d1;
      if (reset) last_exp = '0;
      tick();
      chk($sformatf("rnd%0d err", i), 64'(err), 64'(e));
      chk($sformatf("rnd%0d out_valid", i), 64'(out_valid), 64'(exp_ov));
      chk($sformatf("rnd%0d acc_out", i), 64'(acc_out), 64'(last_exp));
      ov_d1  = cl;
      val_d1 = v;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
